// File: rtl/pattern_bus_writer.sv
// pattern_bus_writer: buffers {timestamp,pattern} chart entries and issues paced, timed writes to the core.
// Optional PATTERN_WRITER_DROP_LATE_EN: late heads are discarded and counted instead of written.
module pattern_bus_writer #(
  parameter int         DEPTH     = 16,
  parameter int         LOOKAHEAD = 4,
  parameter int         GAP       = 2,
  parameter logic [1:0] ADDR_PAT  = 2'd0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     run,
  input  logic                     flush,
  input  logic [9:0]               counter10h,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic [17:0]              load_data,
  output logic                     write,
  output logic [1:0]               address,
  output logic [17:0]              pattern_with_timestamp,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [7:0]               late_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [3:0] GAP_M1 = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_WRITE, S_GAP} state_t;

  state_t        state_q, state_d;
  logic [9:0]    c1_q, c2_q, tick_q, tick_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    gap_q, gap_d;
  logic          write_q, write_d;
  logic [1:0]    address_q, address_d;
  logic [17:0]   pwt_q, pwt_d;
  logic [7:0]    late_q, late_d;
  logic [17:0]   mem_q [DEPTH];

  logic          full, empty, push, pop, due, late;
  logic [17:0]   head;
  logic [9:0]    lead;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign head  = mem_q[rd_ptr_q];
  // Modular distance to the head timestamp; the top half of the ring means "already past".
  assign lead  = head[17:8] - tick_q;
  assign late  = lead[9];
  assign due   = (lead <= 10'(LOOKAHEAD));
  assign push  = load_valid && !full && !flush;
  // The foreign counter is only trusted once two successive samples agree.
  assign tick_d = (c1_q == c2_q) ? c2_q : tick_q;

  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    write_d   = 1'b0;
    address_d = 2'd0;
    pwt_d     = pwt_q;
    late_d    = late_q;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!flush && run && !empty) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (flush || !run || empty) begin
          state_d = S_IDLE;
        end else if (late) begin
          pop    = 1'b1;
          late_d = (late_q == 8'hFF) ? late_q : late_q + 8'd1;
`ifdef PATTERN_WRITER_DROP_LATE_EN
          state_d = S_IDLE;
`else
          write_d   = 1'b1;
          address_d = ADDR_PAT;
          pwt_d     = head;
          state_d   = S_WRITE;
`endif
        end else if (due) begin
          pop       = 1'b1;
          write_d   = 1'b1;
          address_d = ADDR_PAT;
          pwt_d     = head;
          state_d   = S_WRITE;
        end
      end
      S_WRITE: begin
        if (flush || GAP == 0) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_GAP;
          gap_d   = GAP_M1;
        end
      end
      S_GAP: begin
        if (flush || gap_q == 4'd0) state_d = S_IDLE;
        else                        gap_d   = gap_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
    wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(push);
    rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(pop);
    cnt_d    = flush ? '0 : cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      c1_q      <= '0;
      c2_q      <= '0;
      tick_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      gap_q     <= '0;
      write_q   <= 1'b0;
      address_q <= 2'd0;
      pwt_q     <= '0;
      late_q    <= '0;
    end else begin
      state_q   <= state_d;
      c1_q      <= counter10h;
      c2_q      <= c1_q;
      tick_q    <= tick_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      write_q   <= write_d;
      address_q <= address_d;
      pwt_q     <= pwt_d;
      late_q    <= late_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= load_data;
  end

  // A flush landing on the strobe cycle must still suppress the write.
  assign write                  = write_q && !flush;
  assign address                = write ? address_q : 2'd0;
  assign pattern_with_timestamp = pwt_q;
  assign fifo_count             = cnt_q;
  assign late_count             = late_q;
  assign load_ready             = !full;
endmodule

// File: tb/tb_pattern_bus_writer.sv
// Scoreboard bench for pattern_bus_writer: expected writes queued at load time, checked by a write monitor.
module tb_pattern_bus_writer;
  localparam int         DEPTH = 16;
  localparam int         LA    = 4;
  localparam logic [1:0] ADDR  = 2'd0;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0, flush = 1'b0, load_valid = 1'b0;
  logic [9:0]  counter10h = '0;
  logic [17:0] load_data = '0;
  logic        load_ready, write;
  logic [1:0]  address;
  logic [17:0] pwt;
  logic [4:0]  fifo_count;
  logic [7:0]  late_count;

  typedef struct {
    logic [17:0] dat;
    logic [9:0]  ctr;
    bit          chk_ctr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0, failures = 0, wcount = 0;
  logic prev_w = 1'b0;

  pattern_bus_writer #(.DEPTH(DEPTH), .LOOKAHEAD(LA), .GAP(2), .ADDR_PAT(ADDR)) dut (
    .clock(clock), .reset(reset), .run(run), .flush(flush), .counter10h(counter10h),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
    .write(write), .address(address), .pattern_with_timestamp(pwt),
    .fifo_count(fifo_count), .late_count(late_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: every write strobe must match the oldest outstanding expected entry.
  always @(negedge clock) begin
    if (!reset) begin
      if (write) begin
        wcount++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual=%h required=none", pwt);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_data", 32'(pwt), 32'(mon_e.dat));
          chk("wr_addr", 32'(address), 32'(ADDR));
          if (mon_e.chk_ctr) chk("wr_tick", 32'(counter10h), 32'(mon_e.ctr));
        end
        chk("no_adjacent_write", 32'(prev_w), 0);
      end
      prev_w = write;
    end
  end

  task automatic push_entry(input logic [9:0] ts, input logic [7:0] pat, input bit chk_ctr, input bit expect_w);
    exp_t e;
    @(negedge clock);
    load_valid = 1'b1;
    load_data  = {ts, pat};
    if (expect_w) begin
      e.dat = {ts, pat};
      e.ctr = ts - 10'(LA);
      e.chk_ctr = chk_ctr;
      exp_q.push_back(e);
    end
    @(negedge clock);
    load_valid = 1'b0;
  endtask

  task automatic set_ctr(input logic [9:0] v, input int hold);
    @(negedge clock);
    counter10h = v;
    repeat (hold) @(negedge clock);
  endtask

  task automatic do_flush();
    @(negedge clock);
    flush = 1'b1;
    #1 chk("flush_write_low", 32'(write), 0);
    @(negedge clock);
    flush = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    logic [9:0] base, ts, ctr;
    int n, span, nsteps, seen;

    #12;
    chk("rst_write", 32'(write), 0);
    chk("rst_address", 32'(address), 0);
    chk("rst_pwt", 32'(pwt), 0);
    chk("rst_fifo_count", 32'(fifo_count), 0);
    chk("rst_late_count", 32'(late_count), 0);
    chk("rst_load_ready", 32'(load_ready), 1);
    @(negedge clock);
    reset = 1'b0;

    // Held FIFO with run low, then stepped ticks release the three entries.
    push_entry(10'd10, 8'hA1, 1'b1, 1'b1);
    push_entry(10'd20, 8'hB2, 1'b1, 1'b1);
    push_entry(10'd30, 8'hC3, 1'b1, 1'b1);
    repeat (20) @(negedge clock);
    chk("hold_fifo_count", 32'(fifo_count), 3);
    chk("hold_no_write", 32'(wcount), 0);
    run = 1'b1;
    for (int c = 0; c <= 30; c++) set_ctr(10'(c), 24);
    chk("step_write_count", 32'(wcount), 3);
    chk("step_queue_empty", 32'(exp_q.size()), 0);
    chk("step_fifo_empty", 32'(fifo_count), 0);

    // Counter wrap: ts=2 becomes due at counter 1022.
    set_ctr(10'd1020, 8);
    push_entry(10'd2, 8'h5A, 1'b1, 1'b1);
    repeat (24) @(negedge clock);
    chk("wrap_not_due", 32'(exp_q.size()), 1);
    for (int c = 1021; c <= 1023; c++) set_ctr(10'(c), 24);
    chk("wrap_queue_empty", 32'(exp_q.size()), 0);
    chk("wrap_late_zero", 32'(late_count), 0);

    // Late head: ts=5 against tick 100.
    set_ctr(10'd100, 8);
`ifdef PATTERN_WRITER_DROP_LATE_EN
    push_entry(10'd5, 8'h77, 1'b0, 1'b0);
`else
    push_entry(10'd5, 8'h77, 1'b0, 1'b1);
`endif
    repeat (20) @(negedge clock);
    chk("late_count_one", 32'(late_count), 1);
    chk("late_fifo_empty", 32'(fifo_count), 0);
    chk("late_queue_empty", 32'(exp_q.size()), 0);

    // Randomized rounds: increasing timestamps, each written exactly LA ticks early.
    for (int r = 0; r < 4; r++) begin
      base = 10'($urandom_range(0, 1023));
      ctr  = base - 10'(LA + 3);
      set_ctr(ctr, 6);
      n = $urandom_range(3, 10);
      ts = base;
      span = 0;
      for (int i = 0; i < n; i++) begin
        if (i > 0) begin
          int inc;
          inc = $urandom_range(1, 5);
          span += inc;
          ts = ts + 10'(inc);
        end
        push_entry(ts, 8'($urandom_range(0, 255)), 1'b1, 1'b1);
      end
      nsteps = span + 6;
      for (int s = 0; s < nsteps; s++) begin
        set_ctr(ctr, 24);
        ctr = ctr + 10'd1;
      end
      chk("rand_queue_empty", 32'(exp_q.size()), 0);
      chk("rand_fifo_empty", 32'(fifo_count), 0);
    end
    chk("rand_late_unchanged", 32'(late_count), 1);

    // Fill to DEPTH, try one more push, then flush.
    run = 1'b0;
    set_ctr(10'd200, 8);
    for (int i = 0; i < DEPTH; i++) push_entry(10'd300, 8'(i), 1'b1, 1'b1);
    chk("full_load_ready", 32'(load_ready), 0);
    chk("full_count", 32'(fifo_count), DEPTH);
    @(negedge clock);
    load_valid = 1'b1;
    load_data  = {10'd300, 8'hEE};
    @(negedge clock);
    load_valid = 1'b0;
    chk("full_push_ignored", 32'(fifo_count), DEPTH);
    do_flush();
    chk("flush_count_zero", 32'(fifo_count), 0);
    chk("flush_load_ready", 32'(load_ready), 1);

    // Push and pop in the same cycle; also checks the IDLE, CHECK, WRITE latency.
    push_entry(10'd204, 8'h11, 1'b1, 1'b1);
    push_entry(10'd300, 8'h22, 1'b1, 1'b1);
    push_entry(10'd300, 8'h33, 1'b1, 1'b1);
    chk("pp_pre_count", 32'(fifo_count), 3);
    @(negedge clock);
    run = 1'b1;
    @(negedge clock);
    load_valid = 1'b1;
    load_data  = {10'd300, 8'h44};
    begin
      exp_t e;
      e.dat = {10'd300, 8'h44};
      e.ctr = 10'd296;
      e.chk_ctr = 1'b1;
      exp_q.push_back(e);
    end
    @(negedge clock);
    load_valid = 1'b0;
    chk("pp_count_unchanged", 32'(fifo_count), 3);
    chk("pp_write_latency", 32'(write), 1);
    repeat (10) @(negedge clock);
    push_entry(10'd300, 8'h55, 1'b1, 1'b1);
    push_entry(10'd300, 8'h66, 1'b1, 1'b1);
    chk("chk5_count", 32'(fifo_count), 5);
    do_flush();
    chk("chk5_flush_count", 32'(fifo_count), 0);
    repeat (10) @(negedge clock);
    chk("flush_late_kept", 32'(late_count), 1);

    // Asynchronous reset while the strobe is high.
    push_entry(10'd204, 8'h99, 1'b1, 1'b1);
    seen = 0;
    for (int i = 0; i < 30 && seen == 0; i++) begin
      @(negedge clock);
      if (write) seen = 1;
    end
    chk("reset_write_seen", 32'(seen), 1);
    #1 reset = 1'b1;
    #1;
    chk("async_reset_write", 32'(write), 0);
    chk("async_reset_count", 32'(fifo_count), 0);
    chk("async_reset_late", 32'(late_count), 0);
    exp_q.delete();
    @(negedge clock);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    chk("post_reset_quiet", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
